// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area defaults, field widths, scheduler state
// encoding, the request record and the coordinate clamp helper.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;
  localparam int COLOR_W      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef struct packed {
    logic               rel;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } box_req_t;

  // Absolute: val itself. Relative: base + sign-extended val, done two bits
  // wider so neither underflow below 0 nor overflow past 1023 can wrap.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic               rel,
    input logic [COORD_W-1:0] base,
    input logic [COORD_W-1:0] val,
    input logic [COORD_W-1:0] maxv
  );
    logic signed [COORD_W+1:0] sum;
    sum = rel ? ($signed({2'b00, base}) + $signed({{2{val[COORD_W-1]}}, val}))
              : $signed({2'b00, val});
    if (sum[COORD_W+1])                    return '0;
    else if (sum > $signed({2'b00, maxv})) return maxv;
    else                                   return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/vga_vsync_sync.sv
// Brings the asynchronous vsync into sys_clk and emits a registered one-cycle
// frame_tick on the frame-boundary edge (falling for active-low sync).
module vga_vsync_sync #(
  parameter int ACTIVE_LOW = 1
)(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic vsync,
  output logic frame_tick
);

  // Reset to the idle level so leaving reset cannot look like an edge.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  // [0],[1]: two-flop synchronizer, [2]: previous synchronized level.
  logic [2:0] vs_pipe;
  logic       edge_det;

  assign edge_det = IDLE_LVL ? (vs_pipe[2] & ~vs_pipe[1])
                             : (~vs_pipe[2] & vs_pipe[1]);

  // Synchronizer and edge history shift register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) vs_pipe <= {3{IDLE_LVL}};
    else         vs_pipe <= {vs_pipe[1:0], vsync};
  end

  // Registered tick: third cycle after the raw vsync edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) frame_tick <= 1'b0;
    else         frame_tick <= edge_det;
  end

endmodule

// File: rtl/vga_box_sched.sv
// Character-box scheduler: round-robin grant of move/recolour requests from
// two requesters, clamp to the active area, commit only on the frame tick.
module vga_box_sched
  import vga_pkg::*;
#(
  parameter int H_ACTIVE         = H_ACTIVE_DEF,
  parameter int V_ACTIVE         = V_ACTIVE_DEF,
  parameter int BOX_W            = 64,
  parameter int BOX_H            = 32,
  parameter int VSYNC_ACTIVE_LOW = 1
)(
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    vsync,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_rel,
  input  logic [1:0][COORD_W-1:0] req_x,
  input  logic [1:0][COORD_W-1:0] req_y,
  input  logic [1:0][COLOR_W-1:0] req_color,
  output logic [COORD_W-1:0]      char_x_start,
  output logic [COORD_W-1:0]      char_x_end,
  output logic [COORD_W-1:0]      char_y_start,
  output logic [COORD_W-1:0]      char_y_end,
  output logic [COLOR_W-1:0]      char_color,
  output logic                    upd,
  output logic                    busy
);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_ACTIVE - BOX_W);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_ACTIVE - BOX_H);
  localparam logic [COORD_W-1:0] X_RST  = COORD_W'((H_ACTIVE - BOX_W) / 2);
  localparam logic [COORD_W-1:0] Y_RST  = COORD_W'((V_ACTIVE - BOX_H) / 2);
  localparam logic [COORD_W-1:0] W_M1   = COORD_W'(BOX_W - 1);
  localparam logic [COORD_W-1:0] H_M1   = COORD_W'(BOX_H - 1);

  logic [1:0]         state;
  logic               rr_ptr;
  logic               gnt_idx;
  logic               frame_tick;
  logic               commit;
  box_req_t           cur_req;
  box_req_t           req_q;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;

  vga_vsync_sync #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_vs (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  // Preferred requester wins if valid, otherwise the other one.
  assign gnt_idx = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign cur_req = {req_rel[gnt_idx], req_x[gnt_idx], req_y[gnt_idx], req_color[gnt_idx]};
  assign commit  = (state == ST_PEND) && frame_tick;

  // Grant / clamp / wait-for-frame control; ticks outside PEND are dropped.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= 1'b0;
      req_ready <= '0;
      busy      <= 1'b0;
      req_q     <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        ST_IDLE: if (|req_valid) begin
          req_ready <= gnt_idx ? 2'b10 : 2'b01;
          req_q     <= cur_req;
          rr_ptr    <= ~gnt_idx;
          busy      <= 1'b1;
          state     <= ST_CALC;
        end
        // Relative moves are based on the committed box, never pending data.
        ST_CALC: begin
          pend_x <= clamp_coord(req_q.rel, char_x_start, req_q.x, X_MAX);
          pend_y <= clamp_coord(req_q.rel, char_y_start, req_q.y, Y_MAX);
          state  <= ST_PEND;
        end
        ST_PEND: if (frame_tick) begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Committed box registers, touched only on a tick seen in PEND.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      char_x_start <= X_RST;
      char_x_end   <= X_RST + W_M1;
      char_y_start <= Y_RST;
      char_y_end   <= Y_RST + H_M1;
      char_color   <= '1;
      upd          <= 1'b0;
    end else begin
      upd <= commit;
      if (commit) begin
        char_x_start <= pend_x;
        char_x_end   <= pend_x + W_M1;
        char_y_start <= pend_y;
        char_y_end   <= pend_y + H_M1;
        char_color   <= req_q.color;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_sched.sv
// Bench for vga_box_sched: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vga_box_sched;

  localparam int BW = 64;
  localparam int BH = 32;
  localparam int XM = 640 - BW;   // 576
  localparam int YM = 480 - BH;   // 448

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            vsync   = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_rel = '0;
  logic [1:0][9:0] req_x = '0;
  logic [1:0][9:0] req_y = '0;
  logic [1:0][3:0] req_color = '0;
  logic [9:0]      char_x_start, char_x_end, char_y_start, char_y_end;
  logic [3:0]      char_color;
  logic            upd, busy;

  always #5 sys_clk = ~sys_clk;

  vga_box_sched #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(BW), .BOX_H(BH), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .vsync(vsync),
    .req_valid(req_valid), .req_ready(req_ready), .req_rel(req_rel),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .char_x_start(char_x_start), .char_x_end(char_x_end),
    .char_y_start(char_y_start), .char_y_end(char_y_end),
    .char_color(char_color), .upd(upd), .busy(busy)
  );

  typedef struct { int rel; int x; int y; int c; } treq_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  treq_t q0[$];
  treq_t q1[$];
  int    glog[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  int    m_xs = 288, m_ys = 224, m_col = 15;
  int    m_ptr = 0, m_busy = 0, g_edge = 0, tick_edge = -1, cyc_m = 0, vs_q = 1;
  int    e_rdy = 0, e_upd = 0;
  treq_t pend;

  function automatic int sx10(int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  function automatic int clampv(int v, int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    if (sys_rst) begin
      m_xs = 288; m_ys = 224; m_col = 15; m_ptr = 0; m_busy = 0;
      e_rdy = 0; e_upd = 0; vs_q = 1; tick_edge = -1; g_edge = 0;
    end else begin
      int g;
      cyc_m++;
      e_rdy = 0; e_upd = 0;
      // a falling vsync seen now becomes a usable frame boundary 3 edges later
      if (vs_q == 1 && vsync == 1'b0) tick_edge = cyc_m + 3;
      vs_q = int'(vsync);
      if (m_busy != 0) begin
        // commit needs the request to have cleared the clamp cycle first
        if (cyc_m == tick_edge && cyc_m >= g_edge + 2) begin
          m_xs  = clampv((pend.rel != 0) ? m_xs + sx10(pend.x) : pend.x, XM);
          m_ys  = clampv((pend.rel != 0) ? m_ys + sx10(pend.y) : pend.y, YM);
          m_col = pend.c;
          m_busy = 0;
          e_upd  = 1;
        end
      end else if (req_valid != 2'b00) begin
        g = (req_valid[m_ptr] == 1'b1) ? m_ptr : 1 - m_ptr;
        pend.rel = int'(req_rel[g]);
        pend.x   = int'(req_x[g]);
        pend.y   = int'(req_y[g]);
        pend.c   = int'(req_color[g]);
        e_rdy  = 1 << g;
        m_ptr  = 1 - g;
        m_busy = 1;
        g_edge = cyc_m;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge sys_clk);
    chk("x_start", int'(char_x_start), m_xs);
    chk("x_end",   int'(char_x_end),   m_xs + BW - 1);
    chk("y_start", int'(char_y_start), m_ys);
    chk("y_end",   int'(char_y_end),   m_ys + BH - 1);
    chk("color",   int'(char_color),   m_col);
    chk("req_ready", int'(req_ready),  e_rdy);
    chk("upd",     int'(upd),          e_upd);
    chk("busy",    int'(busy),         m_busy);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(int i, treq_t r);
    req_rel[i]   = 1'(r.rel);
    req_x[i]     = 10'(r.x);
    req_y[i]     = 10'(r.y);
    req_color[i] = 4'(r.c);
  endtask

  task automatic advance(int i);
    treq_t r;
    if (i == 0 && q0.size() > 0)      begin r = q0.pop_front(); drive(0, r); end
    else if (i == 1 && q1.size() > 0) begin r = q1.pop_front(); drive(1, r); end
    else req_valid[i] = 1'b0;
  endtask

  // One cycle; requesters react to their accept pulse.
  task automatic step();
    @(negedge sys_clk);
    if (req_ready[0]) begin glog.push_back(0); advance(0); end
    if (req_ready[1]) begin glog.push_back(1); advance(1); end
  endtask

  task automatic submit(int i, int rel, int x, int y, int c);
    treq_t r;
    r.rel = rel; r.x = x; r.y = y; r.c = c;
    if (req_valid[i]) begin
      if (i == 0) q0.push_back(r); else q1.push_back(r);
    end else begin
      drive(i, r);
      req_valid[i] = 1'b1;
    end
  endtask

  // vsync pulse that must produce a commit within a bounded wait
  task automatic frame();
    bit seen = 0;
    vsync = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (upd) seen = 1;
    end
    repeat (5) step();
    vsync = 1'b1;
    repeat (6) step();
    chk("frame_upd_seen", int'(seen), 1);
  endtask

  task automatic pulse_count(output int cnt);
    cnt = 0;
    vsync = 1'b0;
    repeat (12) begin step(); cnt += int'(upd); end
    vsync = 1'b1;
    repeat (6) step();
  endtask

  task automatic chk_box(string tag, int xs, int xe, int ys, int ye, int c);
    chk({tag, "_xs"}, int'(char_x_start), xs);
    chk({tag, "_xe"}, int'(char_x_end),   xe);
    chk({tag, "_ys"}, int'(char_y_start), ys);
    chk({tag, "_ye"}, int'(char_y_end),   ye);
    chk({tag, "_col"}, int'(char_color),  c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    repeat (3) step();
    sys_rst = 1'b0;
    repeat (3) step();
    chk_box("rst", 288, 351, 224, 255, 15);
    chk("rst_busy", int'(busy), 0);

    // absolute move, outputs held until the frame boundary
    submit(0, 0, 100, 50, 3);
    repeat (6) step();
    chk("hold_xs", int'(char_x_start), 288);
    chk("held_busy", int'(busy), 1);
    vsync = 1'b0;
    repeat (3) step();
    chk("lat3_upd", int'(upd), 0);
    step();
    chk("lat4_upd", int'(upd), 1);
    chk_box("abs", 100, 163, 50, 81, 3);
    repeat (5) step();
    vsync = 1'b1;
    repeat (6) step();

    // clamping, absolute past the far edges
    submit(0, 0, 700, 470, 5);
    repeat (4) step();
    frame();
    chk_box("clamp_abs", 576, 639, 448, 479, 5);

    // clamping, relative below zero from (100,50)
    submit(0, 0, 100, 50, 2);
    repeat (4) step();
    frame();
    submit(1, 1, -400, -300, 4);
    repeat (4) step();
    frame();
    chk_box("clamp_rel", 0, 63, 0, 31, 4);

    // arbitration: both requesters valid across four frames
    glog.delete();
    submit(0, 0, 10, 20, 1);
    submit(1, 0, 30, 40, 2);
    submit(0, 1, 5, 5, 3);
    submit(1, 0, 600, 10, 9);
    repeat (4) step();
    frame();
    chk_box("arb1", 10, 73, 20, 51, 1);
    frame();
    chk_box("arb2", 30, 93, 40, 71, 2);
    frame();
    chk_box("arb3", 35, 98, 45, 76, 3);
    frame();
    chk_box("arb4", 576, 639, 10, 41, 9);
    chk("arb_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("arb_g0", glog[0], 0);
      chk("arb_g1", glog[1], 1);
      chk("arb_g2", glog[2], 0);
      chk("arb_g3", glog[3], 1);
    end

    // late tick: boundary lands while the request is being clamped
    vsync = 1'b0;
    step();
    step();
    submit(0, 0, 200, 100, 6);
    cnt = 0;
    repeat (10) begin step(); cnt += int'(upd); end
    chk("late_no_upd", cnt, 0);
    chk("late_hold_xs", int'(char_x_start), 576);
    chk("late_busy", int'(busy), 1);
    vsync = 1'b1;
    repeat (6) step();
    frame();
    chk_box("late", 200, 263, 100, 131, 6);

    // reset while a request is pending
    submit(0, 0, 300, 300, 7);
    repeat (4) step();
    #2 sys_rst = 1'b1;
    #1;
    chk_box("rst_mid", 288, 351, 224, 255, 15);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (2) step();
    sys_rst = 1'b0;
    repeat (3) step();
    pulse_count(cnt);
    chk("rst_no_upd1", cnt, 0);
    pulse_count(cnt);
    chk("rst_no_upd2", cnt, 0);
    chk("rst_after_xs", int'(char_x_start), 288);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required finish before t=200000");
    $fatal(1);
  end

endmodule
